// File: rtl/key_cmd_pkg.sv
// key_cmd_pkg: shared definitions for the push-button command front end.
//   - Command codes, which double as the key index (0 LEFT .. 3 DOWN).
//   - Key count and the mask of keys that auto-repeat.
//   - Arbiter state encoding and the round-robin pick helper.
package key_cmd_pkg;

  localparam logic [1:0] CMD_LEFT  = 2'd0;
  localparam logic [1:0] CMD_RIGHT = 2'd1;
  localparam logic [1:0] CMD_ROT   = 2'd2;
  localparam logic [1:0] CMD_DOWN  = 2'd3;

  localparam int NUM_KEYS = 4;

  // bit0 LEFT .. bit3 DOWN; rotation never auto-repeats
  localparam logic [NUM_KEYS-1:0] REPEAT_EN = 4'b1011;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OFFER = 1'b1
  } arb_state_e;

  // Pick the first pending key after 'last', wrapping; 'last' itself is
  // considered only after every other key. Scanning from the farthest
  // candidate to the nearest lets the nearest pending key win.
  function automatic logic [1:0] rr_pick(input logic [NUM_KEYS-1:0] pend,
                                         input logic [1:0] last);
    logic [1:0] idx;
    rr_pick = last;
    for (int k = NUM_KEYS; k >= 1; k--) begin
      idx = last + k[1:0];
      if (pend[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/key_filter.sv
// key_filter: conditions one raw active-low button.
//   clk, rst_n : clock, synchronous active-low reset
//   key_raw    : asynchronous pin, 0 = pressed
//   level      : debounced level, 0 = pressed
//   press      : one-cycle pulse after level falls 1->0 (no pulse on release)
module key_filter #(
  parameter int DEBOUNCE_CNT = 1_000_000,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CNT);

  logic             sync_p0;
  logic             sync_p1;
  logic             sync_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      sync_prev <= 1'b1;
      cnt       <= '0;
      level     <= 1'b1;
      press     <= 1'b0;
    end else begin
      // synchronizer stages
      sync_p0   <= key_raw;
      sync_p1   <= sync_p0;
      sync_prev <= sync_p1;
      press     <= 1'b0;
      // Any movement of the synchronized input restarts the window; a
      // steady mismatch counts down and the level follows on reaching 1.
      if (sync_p1 != sync_prev) begin
        cnt <= RELOAD;
      end else if (sync_p1 != level) begin
        if (cnt <= CNT_W'(2)) begin
          cnt   <= CNT_W'(1);
          level <= sync_p1;
          press <= ~sync_p1;
        end else begin
          cnt <= cnt - CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/key_cmd_sched.sv
// key_cmd_sched: four-button front end for the block game.
//   sys_clk, sys_rst_n : clock, synchronous active-low reset
//   key_left/right/rot/down : raw pins, 0 = pressed
//   key_state : debounced levels {down, rot, right, left}, 0 = pressed
//   cmd_valid, cmd_code, cmd_ready : command stream (0 LEFT, 1 RIGHT,
//                                    2 ROT, 3 DOWN), one offer at a time
module key_cmd_sched
  import key_cmd_pkg::*;
#(
  parameter int DEBOUNCE_CNT  = 1_000_000,
  parameter int REPEAT_DELAY  = 15_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int CNT_W         = 32
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_rot,
  input  logic       key_down,
  output logic [3:0] key_state,
  output logic       cmd_valid,
  output logic [1:0] cmd_code,
  input  logic       cmd_ready
);

  localparam logic [CNT_W-1:0] RPT_DELAY  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PERIOD = CNT_W'(REPEAT_PERIOD);

  logic [NUM_KEYS-1:0] raw;
  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] press;
  logic [NUM_KEYS-1:0] rpt_fire;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] grant_clr;
  logic [CNT_W-1:0]    rpt_cnt [NUM_KEYS];

  arb_state_e state, state_nxt;
  logic       valid_nxt;
  logic [1:0] code_nxt;
  logic [1:0] last_grant, last_nxt;

  assign raw       = {key_down, key_rot, key_right, key_left};
  assign key_state = level;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_filter #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT),
      .CNT_W       (CNT_W)
    ) u_filter (
      .clk    (sys_clk),
      .rst_n  (sys_rst_n),
      .key_raw(raw[g]),
      .level  (level[g]),
      .press  (press[g])
    );
  end

  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      rpt_fire[i] = REPEAT_EN[i] && !level[i] && (rpt_cnt[i] == CNT_W'(1));
    end
  end

  // auto-repeat timers: idle at 0, armed by the press pulse
  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (!sys_rst_n || !REPEAT_EN[i] || level[i]) begin
        rpt_cnt[i] <= '0;
      end else if (press[i]) begin
        rpt_cnt[i] <= RPT_DELAY;
      end else if (rpt_fire[i]) begin
        rpt_cnt[i] <= RPT_PERIOD;
      end else if (rpt_cnt[i] != '0) begin
        rpt_cnt[i] <= rpt_cnt[i] - CNT_W'(1);
      end
    end
  end

  // pending commands: a new event outranks a same-cycle acceptance
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) pending <= '0;
    else            pending <= press | rpt_fire | (pending & ~grant_clr);
  end

  always_comb begin
    state_nxt = state;
    valid_nxt = cmd_valid;
    code_nxt  = cmd_code;
    last_nxt  = last_grant;
    grant_clr = '0;
    case (state)
      ARB_IDLE: begin
        if (|pending) begin
          code_nxt  = rr_pick(pending, last_grant);
          valid_nxt = 1'b1;
          state_nxt = ARB_OFFER;
        end
      end
      ARB_OFFER: begin
        if (cmd_valid && cmd_ready) begin
          valid_nxt           = 1'b0;
          last_nxt            = cmd_code;
          grant_clr[cmd_code] = 1'b1;
          state_nxt           = ARB_IDLE;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = ARB_IDLE;
      end
    endcase
  end

  // arbiter / output registers
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state      <= ARB_IDLE;
      cmd_valid  <= 1'b0;
      cmd_code   <= CMD_LEFT;
      last_grant <= CMD_DOWN;
    end else begin
      state      <= state_nxt;
      cmd_valid  <= valid_nxt;
      cmd_code   <= code_nxt;
      last_grant <= last_nxt;
    end
  end

endmodule

// File: tb/tb_key_cmd_sched.sv
// tb_key_cmd_sched: directed bench for key_cmd_sched with a scoreboard of
// expected {cmd_code, acceptance cycle}; a monitor pops one entry per
// accepted command. Inputs change 1 time unit after a rising edge, so the
// cycle numbers below count rising edges since the input change.
module tb_key_cmd_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kl, kr, kt, kd;
  logic       ready;
  logic [3:0] ks;
  logic       valid;
  logic [1:0] code;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0] code;
    int         at;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_cmd_sched #(
    .DEBOUNCE_CNT (4),
    .REPEAT_DELAY (20),
    .REPEAT_PERIOD(8),
    .CNT_W        (32)
  ) dut (
    .sys_clk  (clk),
    .sys_rst_n(rst_n),
    .key_left (kl),
    .key_right(kr),
    .key_rot  (kt),
    .key_down (kd),
    .key_state(ks),
    .cmd_valid(valid),
    .cmd_code (code),
    .cmd_ready(ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_cmd(input logic [1:0] c, input int t);
    sb.push_back('{c, t});
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid && ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_cmd: got code %0d at cycle %0d, expected no command", code, cyc);
        end else begin
          e = sb.pop_front();
          chk("cmd_code", 32'(code), 32'(e.code));
          chk("cmd_cycle", 32'(cyc), 32'(e.at));
        end
      end
    end
  endtask

  task automatic run();
    int n;
    int r;
    rst_n = 1'b0;
    kl = 1'b1; kr = 1'b1; kt = 1'b1; kd = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_state", 32'(ks), 32'hF);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_code", 32'(code), 32'd0);
    rst_n = 1'b1;
    wait_to(cyc + 5);

    // clean LEFT tap, 10 cycles low
    n = cyc;
    kl = 1'b0;
    expect_cmd(2'd0, n + 8);
    wait_to(n + 5);  chk("tap_level_before", 32'(ks[0]), 32'd1);
    wait_to(n + 6);  chk("tap_level_after", 32'(ks[0]), 32'd0);
    wait_to(n + 10); kl = 1'b1;
    wait_to(n + 40); chk("tap_idle", 32'(valid), 32'd0);

    // RIGHT chatters for 12 cycles, then steady low for 15
    n = cyc;
    for (int s = 0; s < 6; s++) begin
      kr = s[0];
      wait_to(n + 2 * s + 2);
      chk("chatter_level", 32'(ks[1]), 32'd1);
    end
    kr = 1'b0;
    expect_cmd(2'd1, n + 20);
    wait_to(n + 17); chk("chatter_steady_before", 32'(ks[1]), 32'd1);
    wait_to(n + 18); chk("chatter_steady_after", 32'(ks[1]), 32'd0);
    wait_to(n + 27); kr = 1'b1;
    wait_to(n + 60);

    // DOWN held 40 cycles: press plus repeats at +20, +28, +36
    n = cyc;
    kd = 1'b0;
    expect_cmd(2'd3, n + 8);
    expect_cmd(2'd3, n + 28);
    expect_cmd(2'd3, n + 36);
    expect_cmd(2'd3, n + 44);
    wait_to(n + 40); kd = 1'b1;
    wait_to(n + 80);

    // ROT held 60 cycles: single command
    n = cyc;
    kt = 1'b0;
    expect_cmd(2'd2, n + 8);
    wait_to(n + 60); kt = 1'b1;
    wait_to(n + 90);

    // LEFT, RIGHT, ROT together while the consumer stalls
    n = cyc;
    ready = 1'b0;
    kl = 1'b0; kr = 1'b0; kt = 1'b0;
    wait_to(n + 8);
    chk("stall_valid_first", 32'(valid), 32'd1);
    chk("stall_code_first", 32'(code), 32'd0);
    wait_to(n + 12);
    kl = 1'b1; kr = 1'b1; kt = 1'b1;
    wait_to(n + 17);
    chk("stall_valid_held", 32'(valid), 32'd1);
    chk("stall_code_held", 32'(code), 32'd0);
    wait_to(n + 18);
    ready = 1'b1;
    expect_cmd(2'd0, n + 18);
    expect_cmd(2'd1, n + 20);
    expect_cmd(2'd2, n + 22);
    wait_to(n + 19); chk("no_back_to_back", 32'(valid), 32'd0);
    wait_to(n + 24); chk("stall_drained", 32'(valid), 32'd0);
    wait_to(n + 50);

    // DOWN repeat event lands on the acceptance edge of DOWN
    n = cyc;
    ready = 1'b0;
    kd = 1'b0;
    wait_to(n + 26);
    ready = 1'b1;
    expect_cmd(2'd3, n + 26);
    wait_to(n + 27);
    ready = 1'b0;
    chk("collide_gap", 32'(valid), 32'd0);
    wait_to(n + 28);
    chk("collide_reoffer_valid", 32'(valid), 32'd1);
    chk("collide_reoffer_code", 32'(code), 32'd3);
    ready = 1'b1;
    expect_cmd(2'd3, n + 28);
    expect_cmd(2'd3, n + 36);
    wait_to(n + 32); kd = 1'b1;
    wait_to(n + 70);

    // reset pulse during an offer with LEFT still held
    n = cyc;
    ready = 1'b0;
    kl = 1'b0;
    wait_to(n + 10);
    chk("pre_reset_valid", 32'(valid), 32'd1);
    r = cyc;
    rst_n = 1'b0;
    wait_to(r + 1);
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_key_state", 32'(ks), 32'hF);
    chk("reset_code", 32'(code), 32'd0);
    rst_n = 1'b1;
    ready = 1'b1;
    expect_cmd(2'd0, r + 9);
    wait_to(r + 6); chk("post_reset_level_before", 32'(ks[0]), 32'd1);
    wait_to(r + 7); chk("post_reset_level_after", 32'(ks[0]), 32'd0);
    wait_to(r + 15); kl = 1'b1;
    wait_to(r + 45);
    chk("final_idle", 32'(valid), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      run();
    join_any
    disable fork;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
